// File: rtl/prog_time_base.sv
// Programmable time base: periodic or one-shot tick generator with a
// double-buffered terminal count and a wrapping tick event counter.
module prog_time_base #(
  parameter int CNT_W      = 27,
  parameter int TC_DEFAULT = 99999999,
  parameter int TICK_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mode,
  input  logic              start,
  input  logic              sync_clear,
  input  logic              tc_load,
  input  logic [CNT_W-1:0]  tc_value,
  output logic              tick,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  tc_active,
  output logic              tc_pending,
  output logic              busy,
  output logic [TICK_W-1:0] tick_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0]  TC_RST   = CNT_W'(TC_DEFAULT);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  count_nx;
  logic              tick_nx;
  logic [TICK_W-1:0] tick_cnt_nx;
  logic [CNT_W-1:0]  tc_nx;
  logic [CNT_W-1:0]  pend_val;
  logic [CNT_W-1:0]  pend_nx;
  logic              pending_nx;
  logic              term;
  logic              trig;
  logic              apply;

  assign busy = (state == RUN);

  always_comb begin
    term = (state == RUN) && enable
        && (count >= tc_active);
    trig = (state == IDLE) && enable
        && (!mode || start);
    // A new terminal count may only land on a
    // period boundary; a soft clear defers it.
    apply = ((state == IDLE) || term)
         && !sync_clear;
  end

  always_comb begin
    state_nx    = state;
    count_nx    = count;
    tick_nx     = 1'b0;
    tick_cnt_nx = tick_cnt;

    unique case (state)
      IDLE: begin
        count_nx = '0;
        if (trig) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (term) begin
          count_nx    = '0;
          tick_nx     = 1'b1;
          tick_cnt_nx = tick_cnt + TICK_ONE;
          if (mode) begin
            state_nx = IDLE;
          end
        end else if (enable) begin
          count_nx = count + CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        count_nx = '0;
      end
    endcase

    if (sync_clear) begin
      state_nx    = IDLE;
      count_nx    = '0;
      tick_nx     = 1'b0;
      tick_cnt_nx = '0;
    end
  end

  always_comb begin
    tc_nx      = tc_active;
    pend_nx    = pend_val;
    pending_nx = tc_pending;

    unique case (1'b1)
      tc_load && apply: begin
        tc_nx      = tc_value;
        pending_nx = 1'b0;
      end
      tc_load && !apply: begin
        pend_nx    = tc_value;
        pending_nx = 1'b1;
      end
      !tc_load && apply && tc_pending: begin
        tc_nx      = pend_val;
        pending_nx = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      tick       <= 1'b0;
      tick_cnt   <= '0;
      tc_active  <= TC_RST;
      pend_val   <= '0;
      tc_pending <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      tick       <= tick_nx;
      tick_cnt   <= tick_cnt_nx;
      tc_active  <= tc_nx;
      pend_val   <= pend_nx;
      tc_pending <= pending_nx;
    end
  end

endmodule

// File: tb/tb_prog_time_base.sv
// Directed and randomized checks of prog_time_base against a
// cycle-level behavioural model built from the block's rules.
module tb_prog_time_base;

  localparam int CNT_W  = 8;
  localparam int TC_DEF = 4;
  localparam int TICK_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              mode;
  logic              start;
  logic              sync_clear;
  logic              tc_load;
  logic [CNT_W-1:0]  tc_value;
  logic              tick;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  tc_active;
  logic              tc_pending;
  logic              busy;
  logic [TICK_W-1:0] tick_cnt;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // reference model state
  bit m_run;
  int m_cnt;
  int m_tc;
  int m_q[$];
  bit m_tick;
  int m_tcnt;

  prog_time_base #(
    .CNT_W(CNT_W),
    .TC_DEFAULT(TC_DEF),
    .TICK_W(TICK_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .mode(mode),
    .start(start),
    .sync_clear(sync_clear),
    .tc_load(tc_load),
    .tc_value(tc_value),
    .tick(tick),
    .count(count),
    .tc_active(tc_active),
    .tc_pending(tc_pending),
    .busy(busy),
    .tick_cnt(tick_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(string tag,
                       logic [31:0] obs,
                       logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // One clock edge of the rules, on the inputs present at the edge.
  task automatic model_step();
    bit at_term;
    bit boundary;
    if (reset) begin
      m_run = 0; m_cnt = 0; m_tick = 0;
      m_tcnt = 0; m_tc = TC_DEF; m_q.delete();
      return;
    end
    at_term  = m_run && enable && (m_cnt >= m_tc);
    boundary = (!m_run || at_term) && !sync_clear;
    if (tc_load) begin
      if (boundary) begin
        m_tc = int'(tc_value);
        m_q.delete();
      end else begin
        m_q.delete();
        m_q.push_back(int'(tc_value));
      end
    end else if (boundary && m_q.size() != 0) begin
      m_tc = m_q.pop_front();
    end
    if (sync_clear) begin
      m_run = 0; m_cnt = 0; m_tick = 0; m_tcnt = 0;
      return;
    end
    m_tick = at_term;
    if (!m_run) begin
      m_cnt = 0;
      m_run = enable && (!mode || start);
    end else if (at_term) begin
      m_cnt  = 0;
      m_tcnt = (m_tcnt + 1) % (1 << TICK_W);
      if (mode) m_run = 0;
    end else if (enable) begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("tick", 32'(tick), 32'(m_tick));
    check("count", 32'(count), 32'(m_cnt));
    check("tc_active", 32'(tc_active), 32'(m_tc));
    check("tc_pending", 32'(tc_pending),
          32'(m_q.size() != 0));
    check("busy", 32'(busy), 32'(m_run));
    check("tick_cnt", 32'(tick_cnt), 32'(m_tcnt));
  endtask

  task automatic idle_inputs();
    reset = 0; enable = 0; mode = 0; start = 0;
    sync_clear = 0; tc_load = 0; tc_value = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cycle();
    cycle();
    reset = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    cycle();
    reset = 0;

    // reset values
    check("rst_busy", 32'(busy), 0);
    check("rst_tc", 32'(tc_active), 4);
    check("rst_cnt", 32'(count), 0);

    // periodic
    enable = 1; mode = 0;
    cycle();
    check("per_busy", 32'(busy), 1);
    for (int k = 1; k <= 15; k++) begin
      cycle();
      check("per_tick", 32'(tick), 32'(k % 5 == 0));
    end
    check("per_tcnt", 32'(tick_cnt), 3);

    // one-shot
    do_reset();
    enable = 1; mode = 1; start = 1;
    cycle();
    start = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      check("os_tick", 32'(tick), 32'(k == 5));
      check("os_busy", 32'(busy), 32'(k < 5));
    end

    // terminal count load mid-period
    do_reset();
    enable = 1;
    cycle();
    cycle();
    cycle();
    check("ld_cnt2", 32'(count), 2);
    tc_load = 1; tc_value = 1;
    cycle();
    tc_load = 0;
    check("ld_pend", 32'(tc_pending), 1);
    check("ld_tc_hold", 32'(tc_active), 4);
    for (int k = 4; k <= 9; k++) begin
      cycle();
      check("ld_tick", 32'(tick),
            32'(k == 5 || k == 7 || k == 9));
    end
    check("ld_pend0", 32'(tc_pending), 0);
    check("ld_tc", 32'(tc_active), 1);

    // pause
    do_reset();
    enable = 1;
    cycle();
    for (int k = 1; k <= 3; k++) cycle();
    enable = 0;
    for (int k = 4; k <= 6; k++) begin
      cycle();
      check("pz_cnt", 32'(count), 3);
      check("pz_tick", 32'(tick), 0);
    end
    enable = 1;
    cycle();
    check("pz_tick7", 32'(tick), 0);
    cycle();
    check("pz_tick8", 32'(tick), 1);

    // soft clear, then reset mid-period
    do_reset();
    enable = 1;
    cycle();
    for (int k = 1; k <= 8; k++) cycle();
    check("sc_cnt3", 32'(count), 3);
    check("sc_tcnt1", 32'(tick_cnt), 1);
    sync_clear = 1;
    cycle();
    sync_clear = 0;
    check("sc_cnt", 32'(count), 0);
    check("sc_tcnt", 32'(tick_cnt), 0);
    check("sc_busy", 32'(busy), 0);
    check("sc_tc", 32'(tc_active), 4);
    for (int k = 0; k < 4; k++) cycle();
    reset = 1;
    cycle();
    reset = 0; enable = 0;
    check("rm_tick", 32'(tick), 0);
    check("rm_cnt", 32'(count), 0);
    check("rm_busy", 32'(busy), 0);
    check("rm_tc", 32'(tc_active), 4);

    // tick counter wrap, then zero terminal count
    do_reset();
    enable = 1;
    cycle();
    for (int k = 1; k <= 80; k++) begin
      cycle();
      if (k == 75) check("wr_15", 32'(tick_cnt), 15);
    end
    check("wr_0", 32'(tick_cnt), 0);
    do_reset();
    tc_load = 1; tc_value = 0;
    cycle();
    tc_load = 0;
    check("z_tc", 32'(tc_active), 0);
    check("z_pend", 32'(tc_pending), 0);
    enable = 1;
    cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("z_tick", 32'(tick), 1);
    end

    // randomized traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      reset      = ($urandom_range(199) == 0);
      sync_clear = ($urandom_range(59) == 0);
      tc_load    = ($urandom_range(14) == 0);
      tc_value   = CNT_W'($urandom_range(6));
      enable     = ($urandom_range(99) < 85);
      start      = ($urandom_range(7) == 0);
      if ($urandom_range(39) == 0) mode = ~mode;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
